// File: rtl/mc_control_unit.sv
// State register and control decoder for the multi-cycle RV32I core: registers the
// state chosen by the fsm, decodes state/opcode into datapath controls, tracks halt and retires.
module mc_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       next_state,
  input  logic             bcond,
  input  logic             halt_x17,
  output logic [2:0]       current_state,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             is_halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] IF1 = 3'd0;
  localparam logic [2:0] IF2 = 3'd1;
  localparam logic [2:0] ID  = 3'd2;
  localparam logic [2:0] EX1 = 3'd3;
  localparam logic [2:0] EX2 = 3'd4;
  localparam logic [2:0] MEM = 3'd5;
  localparam logic [2:0] WB  = 3'd6;

  localparam logic [6:0] ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] LOAD           = 7'b0000011;
  localparam logic [6:0] STORE          = 7'b0100011;
  localparam logic [6:0] BRANCH         = 7'b1100011;
  localparam logic [6:0] JAL            = 7'b1101111;
  localparam logic [6:0] JALR           = 7'b1100111;
  localparam logic [6:0] ECALL          = 7'b1110011;

  logic pc_write_d, mem_read_d, mem_write_d, ir_write_d, reg_write_d;
  logic halt_now;
  logic state_known;

  always_comb begin
    pc_write_d  = 1'b0;
    pc_source   = 2'b00;
    iord        = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    ir_write_d  = 1'b0;
    reg_write_d = 1'b0;
    mem_to_reg  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    case (current_state)
      IF1: mem_read_d = 1'b1;
      IF2: begin
        mem_read_d = 1'b1;
        ir_write_d = 1'b1;
        alu_src_b  = 2'b01;
        // A non-halting ECALL retires here; every other opcode retires later.
        if (opcode == ECALL && !halt_x17) pc_write_d = 1'b1;
      end
      ID: alu_src_b = 2'b10;
      EX1: begin
        case (opcode)
          ARITHMETIC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
          end
          ARITHMETIC_IMM: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
          end
          LOAD, STORE, JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
          end
          JAL: alu_src_b = 2'b10;
          BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b01;
            pc_write_d = !bcond;
          end
          default: pc_write_d = 1'b1;
        endcase
      end
      EX2: begin
        pc_write_d = 1'b1;
        pc_source  = 2'b01;
      end
      MEM: begin
        iord = 1'b1;
        if (opcode == LOAD) mem_read_d = 1'b1;
        if (opcode == STORE) begin
          mem_write_d = 1'b1;
          pc_write_d  = 1'b1;
        end
      end
      WB: begin
        reg_write_d = 1'b1;
        pc_write_d  = 1'b1;
        if (opcode == LOAD) begin
          mem_to_reg = 2'b01;
        end else if (opcode == JAL || opcode == JALR) begin
          mem_to_reg = 2'b10;
          pc_source  = 2'b01;
        end
      end
      default: ;
    endcase
  end

  // A halted core must not touch PC, memory, IR or the register file.
  assign pc_write  = pc_write_d  & ~is_halted;
  assign mem_read  = mem_read_d  & ~is_halted;
  assign mem_write = mem_write_d & ~is_halted;
  assign ir_write  = ir_write_d  & ~is_halted;
  assign reg_write = reg_write_d & ~is_halted;

  assign halt_now    = (current_state == IF2) && (opcode == ECALL) && halt_x17 && !is_halted;
  assign state_known = (next_state != 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      current_state <= IF1;
      is_halted     <= 1'b0;
      instr_count   <= '0;
    end else if (!is_halted) begin
      current_state <= state_known ? next_state : IF1;
      if (halt_now) is_halted <= 1'b1;
      if (pc_write) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: stimulus pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares state, control word, halt flag and retire count.
module tb_mc_control_unit;

  localparam int CW = 4;

  localparam logic [2:0] IF1 = 3'd0, IF2 = 3'd1, ID = 3'd2, EX1 = 3'd3,
                         EX2 = 3'd4, MEM = 3'd5, WB = 3'd6;
  localparam logic [6:0] OP_ADD = 7'b0110011, OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                         OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111, OP_ECALL = 7'b1110011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] next_state = 3'd0;
  logic bcond = 1'b0;
  logic halt_x17 = 1'b0;
  logic [2:0] current_state;
  logic pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, is_halted;
  logic [1:0] pc_source, mem_to_reg, alu_src_b, alu_op;
  logic [CW-1:0] instr_count;

  mc_control_unit #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .next_state(next_state), .bcond(bcond),
    .halt_x17(halt_x17), .current_state(current_state), .pc_write(pc_write),
    .pc_source(pc_source), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .is_halted(is_halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic [14:0]   cw;
    logic          h;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  logic [CW-1:0] exp_cnt = '0;

  wire [14:0] act_cw = {pc_write, pc_source, iord, mem_read, mem_write, ir_write, reg_write,
                        mem_to_reg, alu_src_a, alu_src_b, alu_op};

  function automatic logic [14:0] cw(input logic pw, input logic [1:0] ps, input logic io,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic rw, input logic [1:0] m2r, input logic a,
                                     input logic [1:0] b, input logic [1:0] op);
    return {pw, ps, io, mr, mw, irw, rw, m2r, a, b, op};
  endfunction

  localparam logic [14:0] C_IF1    = 15'b0_00_0_1_0_0_0_00_0_00_00;
  localparam logic [14:0] C_IF2    = 15'b0_00_0_1_0_1_0_00_0_01_00;
  localparam logic [14:0] C_IF2R   = 15'b1_00_0_1_0_1_0_00_0_01_00;
  localparam logic [14:0] C_ID     = 15'b0_00_0_0_0_0_0_00_0_10_00;
  localparam logic [14:0] C_EX_ADD = 15'b0_00_0_0_0_0_0_00_1_00_10;
  localparam logic [14:0] C_EX_BT  = 15'b0_00_0_0_0_0_0_00_1_00_01;
  localparam logic [14:0] C_EX_BN  = 15'b1_00_0_0_0_0_0_00_1_00_01;
  localparam logic [14:0] C_EX_LS  = 15'b0_00_0_0_0_0_0_00_1_10_00;
  localparam logic [14:0] C_EX_JAL = 15'b0_00_0_0_0_0_0_00_0_10_00;
  localparam logic [14:0] C_EX2    = 15'b1_01_0_0_0_0_0_00_0_00_00;
  localparam logic [14:0] C_MEM_LW = 15'b0_00_1_1_0_0_0_00_0_00_00;
  localparam logic [14:0] C_MEM_SW = 15'b1_00_1_0_1_0_0_00_0_00_00;
  localparam logic [14:0] C_WB_ADD = 15'b1_00_0_0_0_0_1_00_0_00_00;
  localparam logic [14:0] C_WB_LW  = 15'b1_00_0_0_0_0_1_01_0_00_00;
  localparam logic [14:0] C_WB_JAL = 15'b1_01_0_0_0_0_1_10_0_00_00;
  localparam logic [14:0] C_ZERO   = 15'b0;

  // One cycle of stimulus plus the expected observation for that cycle.
  task automatic step(input logic rs, input logic [6:0] op, input logic [2:0] ns,
                      input logic bc, input logic hx, input logic [2:0] es,
                      input logic [14:0] ecw, input logic eh);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rs; opcode = op; next_state = ns; bcond = bc; halt_x17 = hx;
    if (rs) exp_cnt = '0;
    e.st = es; e.cw = ecw; e.h = eh; e.cnt = exp_cnt;
    exp_q.push_back(e);
    if (ecw[14]) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic fetch(input logic [6:0] op, input logic [2:0] ns_after);
    step(0, op, IF2, 0, 0, IF1, C_IF1, 0);
    step(0, op, ns_after, 0, 0, IF2, C_IF2, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (current_state !== e.st) begin
        failures++;
        $display("FAIL state: got %0d expected %0d at %0t", current_state, e.st, $time);
      end
      checks++;
      if (act_cw !== e.cw) begin
        failures++;
        $display("FAIL ctrl: got %b expected %b at %0t", act_cw, e.cw, $time);
      end
      checks++;
      if (is_halted !== e.h) begin
        failures++;
        $display("FAIL halted: got %b expected %b at %0t", is_halted, e.h, $time);
      end
      checks++;
      if (instr_count !== e.cnt) begin
        failures++;
        $display("FAIL count: got %0d expected %0d at %0t", instr_count, e.cnt, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1, 7'd0, IF1, 0, 0, IF1, C_IF1, 0);
    // ADD
    fetch(OP_ADD, ID);
    step(0, OP_ADD, EX1, 0, 0, ID, C_ID, 0);
    step(0, OP_ADD, WB, 0, 0, EX1, C_EX_ADD, 0);
    step(0, OP_ADD, IF1, 0, 0, WB, C_WB_ADD, 0);
    // BEQ taken
    fetch(OP_BEQ, ID);
    step(0, OP_BEQ, EX1, 0, 0, ID, C_ID, 0);
    step(0, OP_BEQ, EX2, 1, 0, EX1, C_EX_BT, 0);
    step(0, OP_BEQ, IF1, 0, 0, EX2, C_EX2, 0);
    // BEQ not taken
    fetch(OP_BEQ, ID);
    step(0, OP_BEQ, EX1, 0, 0, ID, C_ID, 0);
    step(0, OP_BEQ, IF1, 0, 0, EX1, C_EX_BN, 0);
    // LW
    fetch(OP_LW, ID);
    step(0, OP_LW, EX1, 0, 0, ID, C_ID, 0);
    step(0, OP_LW, MEM, 0, 0, EX1, C_EX_LS, 0);
    step(0, OP_LW, WB, 0, 0, MEM, C_MEM_LW, 0);
    step(0, OP_LW, IF1, 0, 0, WB, C_WB_LW, 0);
    // SW
    fetch(OP_SW, ID);
    step(0, OP_SW, EX1, 0, 0, ID, C_ID, 0);
    step(0, OP_SW, MEM, 0, 0, EX1, C_EX_LS, 0);
    step(0, OP_SW, IF1, 0, 0, MEM, C_MEM_SW, 0);
    // JAL skips ID
    fetch(OP_JAL, EX1);
    step(0, OP_JAL, WB, 0, 0, EX1, C_EX_JAL, 0);
    step(0, OP_JAL, IF1, 0, 0, WB, C_WB_JAL, 0);
    // Undefined next_state code falls back to IF1
    step(0, OP_ADD, 3'd7, 0, 0, IF1, C_IF1, 0);
    step(0, OP_ADD, IF1, 0, 0, IF1, C_IF1, 0);
    // Reset during EX1 of ADD
    fetch(OP_ADD, ID);
    step(0, OP_ADD, EX1, 0, 0, ID, C_ID, 0);
    step(1, OP_ADD, WB, 0, 0, IF1, C_IF1, 0);
    step(0, OP_ADD, IF1, 0, 0, IF1, C_IF1, 0);
    // Non-halting ECALLs: 17 retirements wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      step(0, OP_ECALL, IF2, 0, 0, IF1, C_IF1, 0);
      step(0, OP_ECALL, IF1, 0, 0, IF2, C_IF2R, 0);
    end
    // Halting ECALL, then everything frozen
    step(0, OP_ECALL, IF2, 0, 1, IF1, C_IF1, 0);
    step(0, OP_ECALL, IF1, 0, 1, IF2, C_IF2, 0);
    for (int i = 0; i < 3; i++) step(0, OP_ADD, IF2, 0, 0, IF1, C_ZERO, 1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
